// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side drain engine.
// Buffer depth and occupancy states.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order output buffer with push/pop/clear.
// Entry 0 is always the oldest word; state doubles as level.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output rd_state_t             state_o
);

  rd_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (state_q)
      S_EMPTY: begin
        if (push_i) begin
          e0_d    = din_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        // popping the only entry while a word lands: head replaced
        if (push_i && pop_i) begin
          e0_d = din_i;
        end else if (push_i) begin
          e1_d    = din_i;
          state_d = S_TWO;
        end else if (pop_i) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop_i) begin
          e0_d = e1_q;
          if (push_i) e1_d = din_i;
          else state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (clear_i) state_d = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign head_o  = e0_q;
  assign state_o = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO into a valid/ready stream, hiding the
// one-cycle storage read latency behind a 2-entry buffer.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            buf_level
);

  rd_state_t  state;
  logic       inflight_q, inflight_d;
  logic       pop, capture;
  logic [2:0] outstanding;

  assign m_valid = (state != S_EMPTY);
  assign pop     = m_valid & m_ready;
  assign capture = inflight_q & ~flush;

  // words held plus words requested, after this cycle's pop
  assign outstanding = 3'(state) + 3'(inflight_q) - 3'(pop);

  assign fifo_rd = ~fifo_empty & ~flush & ~reset
                 & (outstanding < 3'(BUF_DEPTH));

  assign inflight_d = fifo_rd;

  always_ff @(posedge clk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .clear_i(flush),
    .push_i (capture),
    .pop_i  (pop),
    .din_i  (fifo_rdata),
    .head_o (m_data),
    .state_o(state)
  );

  assign buf_level = state;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a FIFO model
// and a stream-side monitor.
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, flush, fifo_empty;
  logic         fifo_rd, m_valid, m_ready;
  logic [W-1:0] fifo_rdata = '0;
  logic [W-1:0] m_data;
  logic [1:0]   buf_level;

  logic [W-1:0] mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic [W-1:0] rx [0:63];
  int           rx_n = 0;

  int n_chk  = 0;
  int n_fail = 0;
  int base, npulse;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_rdata(fifo_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .buf_level (buf_level)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && m_valid && m_ready) begin
      rx[rx_n] <= m_data;
      rx_n     <= rx_n + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  initial begin
    logic [W-1:0] e3 [3];
    logic [W-1:0] e5 [5];
    e3 = '{8'h11, 8'h22, 8'h33};
    e5 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    reset   = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33);

    // reset held with a non-empty FIFO
    repeat (3) begin
      cyc();
      chk("rst_rd", fifo_rd, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_level", buf_level, 0);
    end

    // streaming with m_ready high
    reset   = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("t2_rd", fifo_rd, (c < 3));
      chk("t2_valid", m_valid, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4)
        chk("t2_data", m_data, e3[c-2]);
      cyc();
    end

    // backpressure with five words
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(e5[i]);
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      npulse += int'(fifo_rd);
      cyc();
    end
    chk("t3_pulses", npulse, 2);
    chk("t3_level", buf_level, 2);
    chk("t3_valid", m_valid, 1);
    chk("t3_head", m_data, 8'hA1);
    cyc();
    #1;
    chk("t3_hold", m_data, 8'hA1);
    chk("t3_rd_off", fifo_rd, 0);
    m_ready = 1'b1;
    #1;
    chk("t3_release_rd", fifo_rd, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_valid_run", m_valid, 1);
      chk("t3_data_run", m_data, e5[i]);
      cyc();
    end
    chk("t3_level_end", buf_level, 0);

    // toggling m_ready over eight words
    base = rx_n;
    for (int i = 0; i < 8; i++) load(8'h81 + 8'(i));
    for (int c = 0; c < 80 && (rx_n - base) < 8; c++) begin
      m_ready = (c % 2 == 0);
      cyc();
    end
    m_ready = 1'b0;
    chk("t4_count", rx_n - base, 8);
    for (int i = 0; i < 8; i++)
      chk("t4_order", rx[base+i], 8'h81 + 8'(i));

    // flush with one held word and one in flight
    cyc();
    cyc();
    load(8'h5A); load(8'h6B); load(8'h7C);
    #1;
    chk("t5_rd0", fifo_rd, 1);
    cyc();
    cyc();
    #1;
    chk("t5_level_pre", buf_level, 1);
    flush = 1'b1;
    #1;
    chk("t5_rd_flush", fifo_rd, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("t5_level_post", buf_level, 0);
    chk("t5_valid_post", m_valid, 0);
    m_ready = 1'b1;
    base = rx_n;
    repeat (6) cyc();
    chk("t5_count", rx_n - base, 1);
    chk("t5_word", rx[base], 8'h7C);

    // reset with a held word and one in flight
    m_ready = 1'b0;
    load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    cyc();
    cyc();
    #1;
    chk("t6_level_pre", buf_level, 1);
    reset = 1'b1;
    #1;
    chk("t6_rd_rst", fifo_rd, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_data", m_data, 0);
    chk("t6_level", buf_level, 0);
    m_ready = 1'b1;
    base = rx_n;
    repeat (8) cyc();
    chk("t6_count", rx_n - base, 2);
    chk("t6_word0", rx[base], 8'hC3);
    chk("t6_word1", rx[base+1], 8'hC4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
